// File: rtl/ahb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_mem
// Description : AHB-Lite memory slave with programmable wait states, byte
//               strobes, and a two-cycle ERROR response for illegal accesses.
// Revision    : 1.0
// ============================================================================
module ahb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic                    hselx,
  input  logic [ADDR_WIDTH-1:0]   haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
  input  logic [3:0]              hprot,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH/8-1:0] hwstrb,
  input  logic                    hready,
  output logic                    hreadyout,
  output logic [DATA_WIDTH-1:0]   hrdata,
  output logic                    hresp,
  output logic                    hexokay
);

  localparam int         c_NB      = DATA_WIDTH / 8;
  localparam int         c_LB      = $clog2(c_NB);
  localparam int         c_IW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0] c_WS_LOAD = 3'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  state_t                w_acc_state;
  logic [2:0]            r_cnt;
  logic                  r_dp_valid;
  logic                  r_write;
  logic [c_IW-1:0]       r_idx;
  logic [c_NB-1:0]       r_lanes;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] w_word;
  logic [7:0]            w_size_mask;
  logic [c_LB-1:0]       w_win;
  logic [c_NB-1:0]       w_lanes;
  logic                  w_oor;
  logic                  w_bad_size;
  logic                  w_misalign;
  logic                  w_err;
  logic                  w_accept;
  logic                  w_commit;
  logic                  w_rd_en;
  logic                  w_unused;

  // Address-phase decode: range, size and alignment checks
  assign w_word      = haddr >> c_LB;
  assign w_oor       = (w_word >= ADDR_WIDTH'(MEM_DEPTH));
  assign w_bad_size  = (hsize > 3'(c_LB));
  assign w_size_mask = (8'd1 << hsize) - 8'd1;
  assign w_win       = ~w_size_mask[c_LB-1:0];
  assign w_misalign  = |(haddr[c_LB-1:0] & w_size_mask[c_LB-1:0]);
  assign w_err       = w_oor | w_bad_size | w_misalign;

  // A lane belongs to the transfer when it shares the size-aligned base
  for (genvar i = 0; i < c_NB; i++) begin : g_lane
    assign w_lanes[i] = ((c_LB'(i) & w_win) == (haddr[c_LB-1:0] & w_win));
  end

  assign w_accept = hselx & hready & htrans[1] &
                    ((r_state == ST_IDLE) | (r_state == ST_ERR2));
  assign w_commit = (r_state == ST_IDLE) & r_dp_valid & r_write;
  assign w_rd_en  = (r_state == ST_IDLE) & r_dp_valid & ~r_write;

  always_comb begin
    w_acc_state = ST_IDLE;
    if (w_err) begin
      w_acc_state = ST_ERR1;
    end else if (WAIT_STATES > 0) begin
      w_acc_state = ST_WAIT;
    end
  end

  always_comb begin
    w_next    = r_state;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = w_acc_state;
        end
      end
      ST_WAIT: begin
        hreadyout = 1'b0;
        if (r_cnt == 3'd0) begin
          w_next = ST_IDLE;
        end
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        w_next    = ST_ERR2;
      end
      ST_ERR2: begin
        hresp  = 1'b1;
        w_next = w_accept ? w_acc_state : ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // r_dp_valid marks the final (hreadyout=1) cycle of an OKAY data phase
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_dp_valid <= 1'b0;
      r_write    <= 1'b0;
      r_idx      <= '0;
      r_lanes    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt      <= c_WS_LOAD;
        r_write    <= hwrite;
        r_idx      <= haddr[c_LB +: c_IW];
        r_lanes    <= w_lanes;
        r_dp_valid <= ~w_err & (WAIT_STATES == 0);
      end else begin
        if ((r_state == ST_WAIT) && (r_cnt != 3'd0)) begin
          r_cnt <= r_cnt - 3'd1;
        end
        r_dp_valid <= (r_state == ST_WAIT) & (r_cnt == 3'd0);
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      for (int w = 0; w < MEM_DEPTH; w++) begin
        r_mem[w] <= '0;
      end
    end else if (w_commit) begin
      for (int b = 0; b < c_NB; b++) begin
        if (r_lanes[b] && hwstrb[b]) begin
          r_mem[r_idx][8*b +: 8] <= hwdata[8*b +: 8];
        end
      end
    end
  end

  // Memory is read combinationally, so a write committed on the edge that
  // starts a read's data phase is already visible to that read.
  assign hrdata  = w_rd_en ? r_mem[r_idx] : '0;
  assign hexokay = 1'b0;

  assign w_unused = ^{hburst, hprot, htrans[0], w_size_mask[7:c_LB]};

endmodule
`default_nettype wire
